// File: rtl/fetch_unit_if.sv
// fetch_unit_if: decode-facing valid/ready bus carrying an instruction and its next-sequential PC.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) ();
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc_n;
    modport master (output out_valid, out_inst, out_pc_n, input out_ready);
    modport slave  (input out_valid, out_inst, out_pc_n, output out_ready);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator, loadable instruction memory and credit-controlled fetch queue
// with jump redirect; head outputs are registered and zero while invalid.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                IMEM_AW  = 10,
    parameter int                INST_W   = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               is_jmp,
    input  logic [ADDR_W-1:0]  pc_jmp,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [INST_W-1:0]  imem_wdata,
    fetch_unit_if.master       dec
);
    localparam int QAW = $clog2(QDEPTH);
    localparam int CW  = $clog2(QDEPTH + 1);

    logic [INST_W-1:0] mem [2**IMEM_AW];
    logic [INST_W-1:0] rdata;
    logic [INST_W-1:0] q_inst [QDEPTH];
    logic [ADDR_W-1:0] q_pcn [QDEPTH];
    logic [ADDR_W-1:0] fetch_pc, busy_pcn;
    logic              busy;
    logic [QAW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]     count, cnt_pop, count_n;
    logic [CW:0]       used;
    logic              pop, enq, issue, ov, ov_n;
    logic [INST_W-1:0] oi, oi_n;
    logic [ADDR_W-1:0] op, op_n;

    // Credit counts the in-flight read so an enqueue can never find the queue full.
    always_comb begin
        pop     = ov & dec.out_ready;
        enq     = busy & ~is_jmp;
        used    = {1'b0, count} + (CW+1)'(busy) - (CW+1)'(pop);
        issue   = ~is_jmp & (used < (CW+1)'(QDEPTH));
        cnt_pop = count - CW'(pop);
        rd_nxt  = rd_ptr + QAW'(pop);
        count_n = cnt_pop + CW'(enq);
        ov_n    = ~is_jmp & (count_n != '0);
        oi_n    = !ov_n ? '0 : (cnt_pop != '0) ? q_inst[rd_nxt] : rdata;
        op_n    = !ov_n ? '0 : (cnt_pop != '0) ? q_pcn[rd_nxt] : busy_pcn;
    end

    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
        if (issue) rdata <= mem[fetch_pc[IMEM_AW-1:0]];
        if (enq) begin
            q_inst[wr_ptr] <= rdata;
            q_pcn[wr_ptr]  <= busy_pcn;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            busy     <= 1'b0;
            busy_pcn <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ov       <= 1'b0;
            oi       <= '0;
            op       <= '0;
        end else begin
            if (is_jmp) begin
                fetch_pc <= pc_jmp;
                busy     <= 1'b0;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                    busy_pcn <= fetch_pc + ADDR_W'(1);
                end
                busy   <= issue;
                count  <= count_n;
                wr_ptr <= wr_ptr + QAW'(enq);
                rd_ptr <= rd_nxt;
            end
            ov <= ov_n;
            oi <= oi_n;
            op <= op_n;
        end
    end

    assign dec.out_valid = ov;
    assign dec.out_inst  = oi;
    assign dec.out_pc_n  = op;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus; expected stream entries queued per cycle,
// checked by a negedge monitor against accepted beats, tagged by redirect/reset epoch.
module tb_fetch_unit;
    localparam int AW = 12, IAW = 10, IW = 32, QD = 4;

    logic clk = 0, rst = 0, is_jmp = 0, imem_we = 0;
    logic [AW-1:0]  pc_jmp = '0;
    logic [IAW-1:0] imem_waddr = '0;
    logic [IW-1:0]  imem_wdata = '0;

    fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) dec ();

    fetch_unit #(.ADDR_W(AW), .IMEM_AW(IAW), .INST_W(IW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .is_jmp(is_jmp), .pc_jmp(pc_jmp),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dec(dec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ep;
        logic [IW-1:0] inst;
        logic [AW-1:0] pcn;
    } exp_t;

    exp_t          sb[$];
    exp_t          e, m;
    logic [IW-1:0] mem_model [1024];
    logic [IW-1:0] prog [4];
    logic [AW-1:0] seg_pc = '0;
    int            errors = 0, checks = 0, drv_ep = 0, mon_ep = 0, beats = 0;
    logic          prev_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected stream continues from seg_pc; one entry per cycle always stays ahead of delivery.
    task automatic tick();
        e.ep   = drv_ep;
        e.inst = mem_model[seg_pc[IAW-1:0]];
        e.pcn  = seg_pc + AW'(1);
        sb.push_back(e);
        seg_pc = seg_pc + AW'(1);
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [AW-1:0] t);
        is_jmp = 1'b1;
        pc_jmp = t;
        drv_ep++;
        seg_pc = t;
        tick();
        is_jmp = 1'b0;
    endtask

    task automatic restart();
        rst = 1'b0;
        drv_ep++;
        seg_pc = '0;
        tick();
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (dec.out_valid && dec.out_ready) begin
            beats++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected got pc_n=%h exp=no_entry", dec.out_pc_n);
            end else begin
                m = sb.pop_front();
                chk("beat_epoch", 32'(mon_ep), 32'(m.ep));
                chk("beat_inst", dec.out_inst, m.inst);
                chk("beat_pcn", 32'(dec.out_pc_n), 32'(m.pcn));
            end
        end else if (!dec.out_valid) begin
            chk("idle_inst", dec.out_inst, 32'h0);
            chk("idle_pcn", 32'(dec.out_pc_n), 32'h0);
        end
        if (is_jmp || (!rst && prev_rst)) begin
            mon_ep++;
            while (sb.size() != 0 && sb[0].ep < mon_ep) sb.delete(0);
        end
        prev_rst = rst;
    end

    initial begin
        dec.out_ready = 1'b0;
        prog[0] = 32'h05110003;
        prog[1] = 32'h055d0001;
        prog[2] = 32'h07b80000;
        prog[3] = 32'h02a26000;
        drv_ep = 1;
        for (int i = 0; i < 1024; i++) mem_model[i] = (i < 4) ? prog[i] : $urandom;
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) begin
            imem_we    = 1'b1;
            imem_waddr = IAW'(i);
            imem_wdata = mem_model[i];
            @(posedge clk);
            #1;
        end
        imem_we = 1'b0;
        chk("rst_valid", 32'(dec.out_valid), 0);
        chk("rst_inst", dec.out_inst, 0);
        chk("rst_pcn", 32'(dec.out_pc_n), 0);

        // startup latency and program order
        dec.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        chk("start_edge1_valid", 32'(dec.out_valid), 0);
        tick();
        chk("start_edge2_valid", 32'(dec.out_valid), 1);
        chk("start_inst0", dec.out_inst, prog[0]);
        chk("start_pcn0", 32'(dec.out_pc_n), 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("start_inst", dec.out_inst, prog[k]);
            chk("start_pcn", 32'(dec.out_pc_n), 32'(k + 1));
        end

        // backpressure: queue saturates then drains without gaps
        dec.out_ready = 1'b0;
        restart();
        repeat (10) tick();
        chk("bp_hold_valid", 32'(dec.out_valid), 1);
        chk("bp_hold_pcn", 32'(dec.out_pc_n), 1);
        dec.out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            chk("bp_run_pcn", 32'(dec.out_pc_n), 32'(k));
            tick();
        end

        // redirect into a full queue
        dec.out_ready = 1'b0;
        repeat (6) tick();
        jump(AW'(8));
        chk("jmp_bubble0", 32'(dec.out_valid), 0);
        tick();
        chk("jmp_bubble1", 32'(dec.out_valid), 0);
        tick();
        chk("jmp_valid", 32'(dec.out_valid), 1);
        chk("jmp_inst", dec.out_inst, mem_model[8]);
        chk("jmp_pcn", 32'(dec.out_pc_n), 9);

        // redirect coincident with pop and an in-flight read
        dec.out_ready = 1'b1;
        repeat (5) tick();
        jump(AW'(12'h020));
        chk("jmppop_bubble0", 32'(dec.out_valid), 0);
        tick();
        chk("jmppop_bubble1", 32'(dec.out_valid), 0);
        tick();
        chk("jmppop_pcn", 32'(dec.out_pc_n), 32'h21);
        chk("jmppop_inst", dec.out_inst, mem_model[32]);

        // PC wrap
        jump(AW'(12'hFFF));
        tick();
        tick();
        chk("wrap_pcn0", 32'(dec.out_pc_n), 32'h000);
        chk("wrap_inst0", dec.out_inst, mem_model[1023]);
        tick();
        chk("wrap_pcn1", 32'(dec.out_pc_n), 32'h001);
        chk("wrap_inst1", dec.out_inst, mem_model[0]);

        // asynchronous reset pulse between edges
        repeat (3) tick();
        rst = 1'b0;
        drv_ep++;
        seg_pc = '0;
        #2;
        chk("arst_valid", 32'(dec.out_valid), 0);
        chk("arst_inst", dec.out_inst, 0);
        chk("arst_pcn", 32'(dec.out_pc_n), 0);
        #4;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();
        chk("arst_restart_valid", 32'(dec.out_valid), 1);
        chk("arst_restart_pcn", 32'(dec.out_pc_n), 1);
        chk("arst_mem_intact", dec.out_inst, prog[0]);

        // random backpressure and redirects
        for (int n = 0; n < 3000; n++) begin
            dec.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0)
                jump(($urandom_range(0, 7) == 0) ? AW'(12'hFFE) : AW'($urandom));
            else
                tick();
        end
        dec.out_ready = 1'b1;
        repeat (8) tick();
        chk("beats_seen", 32'(beats > 1000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
